calendar_gen: RTL and testbench
===============================

Name: calendar_gen

Overview:
- Parametrised BCD calendar for the electric-clock design; next generation of the existing calendar.
- Keeps the date as {YYYY,MM,DD} in BCD and advances it on the day-carry pulse from the time-of-day counter.
- Adds true month lengths with Gregorian leap years, edge-detected manual field increments, validated parallel load, weekday tracking and a configurable year range.
- Feeds the display mux through Data.

Parameters:
- RESET_DATE, 32'h2025_0906, BCD {YYYY,MM,DD} loaded on reset; must be a valid date inside the year range.
- RESET_WDAY, 3'd6, weekday on reset (0=Sun..6=Sat).
- MIN_YEAR, 16'h2000, lowest year, BCD.
- MAX_YEAR, 16'h2099, highest year, BCD; the year wraps MAX_YEAR->MIN_YEAR.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- full_flag  in  1  one-cycle day-carry pulse from the time counter.
- cnt_inc  in  3  manual increment level inputs: [0] day, [1] month, [2] year.
- load_en  in  1  one-cycle load strobe.
- load_data  in  32  BCD {YYYY,MM,DD} to load.
- load_wday  in  3  weekday to load with load_data.
- Data  out  32  current date, BCD {YYYY,MM,DD}.
- wday  out  3  current weekday, 0..6.
- leap  out  1  current year is a leap year (combinational from Data).
- year_wrap  out  1  one-cycle pulse when the year wraps MAX_YEAR->MIN_YEAR.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (async, active-high):
  - Data=RESET_DATE, wday=RESET_WDAY.
  - year_wrap=0, load_err=0.
  - cnt_inc edge registers cleared to 0.
- All updates are registered and become visible on Data/wday one cycle after the causing input is sampled.
- Priority per cycle is load_en > full_flag > manual increment. A manual edge that loses priority is dropped, not queued.
- Month length:
  - 31 for months 01,03,05,07,08,10,12.
  - 30 for months 04,06,09,11.
  - 02: 29 if leap, else 28.
- Leap rule, all in BCD with no binary conversion:
  - yy = low two digits. yy divisible by 4: tens even and ones in {0,4,8}, or tens odd and ones in {2,6}.
  - leap = (yy!=00 and yy divisible by 4) or (yy==00 and high two digits divisible by 4).
- full_flag:
  - day+1. If day==month length: day=01, month+1.
  - If month was 12: month=01, year+1.
  - If year was MAX_YEAR: year=MIN_YEAR and year_wrap=1 for one cycle.
  - wday advances 6->0.
  - BCD carries per digit, e.g. 09->10 and 0999->1000.
- Manual increments:
  - Act on the rising edge of each cnt_inc bit, one step per 0->1 transition. A held level does nothing further.
  - Multiple bits rising in the same cycle: only the lowest-index bit is applied (day > month > year).
  - Day: wraps month length->01, no month carry.
  - Month: 12->01, no year carry.
  - Year: MAX_YEAR->MIN_YEAR; year_wrap is not pulsed on a manual wrap.
  - After a month or year step, day is clamped to the new month length (e.g. 2024-02-29 + year -> 2025-02-28).
  - Manual steps never change wday.
- Load is accepted only if all of the following hold:
  - every nibble is 0-9;
  - month 01-12;
  - day 01..month length, with leap computed from the loaded year;
  - MIN_YEAR<=year<=MAX_YEAR;
  - load_wday<=6.
- Accepted load: Data=load_data and wday=load_wday next cycle.
- Rejected load: Data and wday unchanged, load_err=1 for one cycle, and full_flag/manual input in that cycle are still dropped.
- Mid-operation reset overrides everything asynchronously. Edges present at release are not detected until the input next rises from 0.

Decomposition:
- Shared package calendar_pkg holds:
  - BCD date field slice constants (YEAR/MONTH/DAY bit ranges);
  - month BCD constants M_JAN..M_DEC;
  - weekday encoding SUN=0..SAT=6;
  - the functions bcd_is_leap(year) and bcd_month_len(month, leap).
- One sub-module, calendar_edge_det (per-bit rising-edge detector, width parameter, async active-high reset), used for cnt_inc.

Test Plan:
- Reset release, no inputs -> Data=32'h2025_0906, wday=6, leap=0. Then 3 full_flag pulses -> Data=32'h2025_0909, wday=2.
- Load 32'h2024_0228, wday=3; 2 full_flag -> 2024_0229 (wday 4), then 2024_0301 (wday 5). Repeat with 2100_0228 (MAX_YEAR=16'h2199) -> 2100_0301 (2100 is not leap). Repeat with 2000_0228 -> 2000_0229 (2000 is leap).
- Load 32'h2099_1231; full_flag -> Data=32'h2000_0101, year_wrap=1 for exactly one cycle.
- Hold cnt_inc=3'b001 for 100 cycles from 2025_0930 -> exactly one step to 2025_0901. cnt_inc=3'b010 -> 2025_1001. With 2024_0131, month step -> 2024_0229 (clamped). cnt_inc=3'b100 on 2024_0229 -> 2025_0228. wday unchanged throughout.
- Load invalid values: 32'h2025_1301, 32'h2025_0231, 32'h2025_0A01, 32'h1999_0101 -> each gives a load_err one-cycle pulse and Data unchanged. load_en and full_flag in the same cycle with a valid load -> loaded value, no increment.
- Assert Reset mid-count while cnt_inc=3'b001 is held -> Data=RESET_DATE immediately (async). After release with cnt_inc still high -> no step until cnt_inc goes 0 and then 1.

Source files
------------

// File: rtl/calendar_pkg.sv
// rtl/calendar_pkg.sv - shared BCD date fields, month/weekday encodings and calendar helpers
package calendar_pkg;

    localparam int YEAR_HI  = 31;
    localparam int YEAR_LO  = 16;
    localparam int MONTH_HI = 15;
    localparam int MONTH_LO = 8;
    localparam int DAY_HI   = 7;
    localparam int DAY_LO   = 0;

    localparam logic [7:0] M_JAN = 8'h01;
    localparam logic [7:0] M_FEB = 8'h02;
    localparam logic [7:0] M_MAR = 8'h03;
    localparam logic [7:0] M_APR = 8'h04;
    localparam logic [7:0] M_MAY = 8'h05;
    localparam logic [7:0] M_JUN = 8'h06;
    localparam logic [7:0] M_JUL = 8'h07;
    localparam logic [7:0] M_AUG = 8'h08;
    localparam logic [7:0] M_SEP = 8'h09;
    localparam logic [7:0] M_OCT = 8'h10;
    localparam logic [7:0] M_NOV = 8'h11;
    localparam logic [7:0] M_DEC = 8'h12;

    typedef enum logic [2:0] {
        SUN = 3'd0,
        MON = 3'd1,
        TUE = 3'd2,
        WED = 3'd3,
        THU = 3'd4,
        FRI = 3'd5,
        SAT = 3'd6
    } wday_e;

    // Two BCD digits divisible by 4: even tens need ones 0/4/8, odd tens need 2/6.
    function automatic logic bcd_div4(input logic [7:0] v);
        if (v[4])
            return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
        else
            return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
    endfunction

    function automatic logic bcd_is_leap(input logic [15:0] year);
        if (year[7:0] != 8'h00)
            return bcd_div4(year[7:0]);
        else
            return bcd_div4(year[15:8]);
    endfunction

    function automatic logic [7:0] bcd_month_len(input logic [7:0] month, input logic leap);
        case (month)
            M_FEB:                         return leap ? 8'h29 : 8'h28;
            M_APR, M_JUN, M_SEP, M_NOV:    return 8'h30;
            default:                       return 8'h31;
        endcase
    endfunction

    function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_digits_ok(input logic [31:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (v[4*i +: 4] > 4'd9)
                ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/calendar_edge_det.sv
// rtl/calendar_edge_det.sv - per-bit rising-edge detector for the manual increment inputs
module calendar_edge_det #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] level_i,
    output logic [WIDTH-1:0] rise_o
);

    // A bit is armed only after its input has been seen low, so a level held
    // through reset release never produces a step.
    logic [WIDTH-1:0] armed_q;
    logic [WIDTH-1:0] armed_d;

    always_comb begin
        armed_d = ~level_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            armed_q <= '0;
        else
            armed_q <= armed_d;
    end

    assign rise_o = level_i & armed_q;

endmodule

// File: rtl/calendar_gen.sv
// rtl/calendar_gen.sv - BCD calendar with leap years, manual steps, validated load and weekday
module calendar_gen
    import calendar_pkg::*;
#(
    parameter logic [31:0] RESET_DATE = 32'h2025_0906,
    parameter logic [2:0]  RESET_WDAY = 3'd6,
    parameter logic [15:0] MIN_YEAR   = 16'h2000,
    parameter logic [15:0] MAX_YEAR   = 16'h2099
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        full_flag,
    input  logic [2:0]  cnt_inc,
    input  logic        load_en,
    input  logic [31:0] load_data,
    input  logic [2:0]  load_wday,
    output logic [31:0] Data,
    output logic [2:0]  wday,
    output logic        leap,
    output logic        year_wrap,
    output logic        load_err
);

    logic [31:0] date_q, date_d;
    logic [2:0]  wday_q, wday_d;
    logic        year_wrap_q, year_wrap_d;
    logic        load_err_q, load_err_d;
    logic [2:0]  inc_rise;

    calendar_edge_det #(.WIDTH(3)) u_inc_edge (
        .clk     (Clk),
        .rst     (Reset),
        .level_i (cnt_inc),
        .rise_o  (inc_rise)
    );

    logic [15:0] cur_year, step_year, ld_year;
    logic [7:0]  cur_month, cur_day, step_month, ld_month, ld_day;
    logic [7:0]  cur_len, len_after_month, len_after_year, ld_len;
    logic        cur_leap, load_ok;

    assign cur_year   = date_q[YEAR_HI:YEAR_LO];
    assign cur_month  = date_q[MONTH_HI:MONTH_LO];
    assign cur_day    = date_q[DAY_HI:DAY_LO];
    assign cur_leap   = bcd_is_leap(cur_year);
    assign cur_len    = bcd_month_len(cur_month, cur_leap);

    assign step_month = (cur_month == M_DEC) ? M_JAN : bcd_inc8(cur_month);
    assign step_year  = (cur_year == MAX_YEAR) ? MIN_YEAR : bcd_inc16(cur_year);
    assign len_after_month = bcd_month_len(step_month, cur_leap);
    assign len_after_year  = bcd_month_len(cur_month, bcd_is_leap(step_year));

    // Month length of a loaded date depends on the loaded year, not the current one.
    assign ld_year  = load_data[YEAR_HI:YEAR_LO];
    assign ld_month = load_data[MONTH_HI:MONTH_LO];
    assign ld_day   = load_data[DAY_HI:DAY_LO];
    assign ld_len   = bcd_month_len(ld_month, bcd_is_leap(ld_year));
    assign load_ok  = bcd_digits_ok(load_data)
                   && (ld_month >= M_JAN) && (ld_month <= M_DEC)
                   && (ld_day >= 8'h01) && (ld_day <= ld_len)
                   && (ld_year >= MIN_YEAR) && (ld_year <= MAX_YEAR)
                   && (load_wday <= 3'd6);

    always_comb begin
        date_d      = date_q;
        wday_d      = wday_q;
        year_wrap_d = 1'b0;
        load_err_d  = 1'b0;
        if (load_en) begin
            if (load_ok) begin
                date_d = load_data;
                wday_d = load_wday;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (full_flag) begin
            wday_d = (wday_q == SAT) ? SUN : wday_q + 3'd1;
            if (cur_day == cur_len) begin
                date_d[DAY_HI:DAY_LO] = 8'h01;
                date_d[MONTH_HI:MONTH_LO] = step_month;
                if (cur_month == M_DEC) begin
                    date_d[YEAR_HI:YEAR_LO] = step_year;
                    year_wrap_d = (cur_year == MAX_YEAR);
                end
            end else begin
                date_d[DAY_HI:DAY_LO] = bcd_inc8(cur_day);
            end
        end else if (inc_rise[0]) begin
            date_d[DAY_HI:DAY_LO] = (cur_day == cur_len) ? 8'h01 : bcd_inc8(cur_day);
        end else if (inc_rise[1]) begin
            date_d[MONTH_HI:MONTH_LO] = step_month;
            date_d[DAY_HI:DAY_LO] = (cur_day > len_after_month) ? len_after_month : cur_day;
        end else if (inc_rise[2]) begin
            date_d[YEAR_HI:YEAR_LO] = step_year;
            date_d[DAY_HI:DAY_LO] = (cur_day > len_after_year) ? len_after_year : cur_day;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            date_q      <= RESET_DATE;
            wday_q      <= RESET_WDAY;
            year_wrap_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            date_q      <= date_d;
            wday_q      <= wday_d;
            year_wrap_q <= year_wrap_d;
            load_err_q  <= load_err_d;
        end
    end

    assign Data      = date_q;
    assign wday      = wday_q;
    assign leap      = cur_leap;
    assign year_wrap = year_wrap_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_calendar_gen.sv
// tb/tb_calendar_gen.sv - randomized and directed bench for calendar_gen against an integer date model
module tb_calendar_gen;

    localparam logic [31:0] RST_DATE = 32'h2025_0906;
    localparam int MINY = 2000;
    localparam int MAXY = 2099;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        full_flag = 1'b0;
    logic [2:0]  cnt_inc = 3'b000;
    logic        load_en = 1'b0;
    logic [31:0] load_data = 32'h0;
    logic [2:0]  load_wday = 3'd0;
    logic [31:0] Data, Data2;
    logic [2:0]  wday, wday2;
    logic        leap, leap2, year_wrap, year_wrap2, load_err, load_err2;

    calendar_gen dut (
        .Clk(Clk), .Reset(Reset), .full_flag(full_flag), .cnt_inc(cnt_inc),
        .load_en(load_en), .load_data(load_data), .load_wday(load_wday),
        .Data(Data), .wday(wday), .leap(leap), .year_wrap(year_wrap), .load_err(load_err)
    );

    calendar_gen #(.MAX_YEAR(16'h2199)) dut_wide (
        .Clk(Clk), .Reset(Reset), .full_flag(full_flag), .cnt_inc(cnt_inc),
        .load_en(load_en), .load_data(load_data), .load_wday(load_wday),
        .Data(Data2), .wday(wday2), .leap(leap2), .year_wrap(year_wrap2), .load_err(load_err2)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: plain integer year/month/day with Gregorian arithmetic.
    int       my, mm, md, mw;
    bit       mwrap, merr;
    logic [2:0] mprev;

    function automatic bit leap_i(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int mlen_i(input int m, input int y);
        case (m)
            2:             return leap_i(y) ? 29 : 28;
            4, 6, 9, 11:   return 30;
            default:       return 31;
        endcase
    endfunction

    function automatic int b2i(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [31:0] i2b(input int y, input int m, input int d);
        return {4'(y / 1000 % 10), 4'(y / 100 % 10), 4'(y / 10 % 10), 4'(y % 10),
                4'(m / 10), 4'(m % 10), 4'(d / 10), 4'(d % 10)};
    endfunction

    task automatic model_reset();
        my = 2025; mm = 9; md = 6; mw = 6;
        mprev = 3'b111;
        mwrap = 1'b0; merr = 1'b0;
    endtask

    task automatic model_update();
        logic [2:0]  rise;
        logic [31:0] ld;
        bit          ok;
        int          y, m, d;
        rise  = cnt_inc & ~mprev;
        mprev = cnt_inc;
        mwrap = 1'b0;
        merr  = 1'b0;
        if (load_en) begin
            ld = load_data;
            ok = 1'b1;
            for (int i = 0; i < 8; i++)
                if (ld[4*i +: 4] > 4'd9) ok = 1'b0;
            y = b2i(ld[31:16]);
            m = b2i({8'h00, ld[15:8]});
            d = b2i({8'h00, ld[7:0]});
            if (m < 1 || m > 12) ok = 1'b0;
            else if (d < 1 || d > mlen_i(m, y)) ok = 1'b0;
            if (y < MINY || y > MAXY) ok = 1'b0;
            if (load_wday > 3'd6) ok = 1'b0;
            if (ok) begin
                my = y; mm = m; md = d; mw = int'(load_wday);
            end else begin
                merr = 1'b1;
            end
        end else if (full_flag) begin
            mw = (mw + 1) % 7;
            md++;
            if (md > mlen_i(mm, my)) begin
                md = 1;
                mm++;
                if (mm > 12) begin
                    mm = 1;
                    my++;
                    if (my > MAXY) begin
                        my = MINY;
                        mwrap = 1'b1;
                    end
                end
            end
        end else if (rise[0]) begin
            md = (md == mlen_i(mm, my)) ? 1 : md + 1;
        end else if (rise[1]) begin
            mm = mm % 12 + 1;
            if (md > mlen_i(mm, my)) md = mlen_i(mm, my);
        end else if (rise[2]) begin
            my = (my == MAXY) ? MINY : my + 1;
            if (md > mlen_i(mm, my)) md = mlen_i(mm, my);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        if (Reset) model_reset();
        else model_update();
        #1;
        check("data", Data, i2b(my, mm, md));
        check("wday", {29'd0, wday}, mw);
        check("leap", {31'd0, leap}, {31'd0, leap_i(my)});
        check("year_wrap", {31'd0, year_wrap}, {31'd0, mwrap});
        check("load_err", {31'd0, load_err}, {31'd0, merr});
    endtask

    task automatic do_load(input logic [31:0] v, input logic [2:0] wd);
        load_en = 1'b1; load_data = v; load_wday = wd;
        step();
        load_en = 1'b0;
    endtask

    logic [31:0] bad_loads [4];

    initial begin
        bad_loads[0] = 32'h2025_1301;
        bad_loads[1] = 32'h2025_0231;
        bad_loads[2] = 32'h2025_0A01;
        bad_loads[3] = 32'h1999_0101;

        model_reset();
        step(); step();
        Reset = 1'b0;
        step();
        check("rst_data", Data, 32'h2025_0906);
        check("rst_wday", {29'd0, wday}, 32'd6);
        check("rst_leap", {31'd0, leap}, 32'd0);

        full_flag = 1'b1; repeat (3) step(); full_flag = 1'b0;
        check("ff3_data", Data, 32'h2025_0909);
        check("ff3_wday", {29'd0, wday}, 32'd2);

        do_load(32'h2024_0228, 3'd3);
        full_flag = 1'b1;
        step();
        check("leap_0229", Data, 32'h2024_0229);
        check("leap_0229_wday", {29'd0, wday}, 32'd4);
        step();
        check("leap_0301", Data, 32'h2024_0301);
        check("leap_0301_wday", {29'd0, wday}, 32'd5);
        full_flag = 1'b0;

        do_load(32'h2100_0228, 3'd0);
        check("y2100_narrow_err", {31'd0, load_err}, 32'd1);
        check("y2100_wide_load", Data2, 32'h2100_0228);
        check("y2100_wide_leap", {31'd0, leap2}, 32'd0);
        full_flag = 1'b1; step(); full_flag = 1'b0;
        check("y2100_wide_0301", Data2, 32'h2100_0301);

        do_load(32'h2000_0228, 3'd1);
        full_flag = 1'b1; step(); full_flag = 1'b0;
        check("y2000_0229", Data, 32'h2000_0229);
        check("y2000_leap", {31'd0, leap}, 32'd1);

        do_load(32'h2099_1231, 3'd2);
        full_flag = 1'b1; step(); full_flag = 1'b0;
        check("wrap_data", Data, 32'h2000_0101);
        check("wrap_pulse", {31'd0, year_wrap}, 32'd1);
        step();
        check("wrap_pulse_end", {31'd0, year_wrap}, 32'd0);

        do_load(32'h2025_0930, 3'd3);
        cnt_inc = 3'b001; repeat (100) step();
        check("hold_day", Data, 32'h2025_0901);
        cnt_inc = 3'b000; step();
        cnt_inc = 3'b010; step();
        check("man_month", Data, 32'h2025_1001);
        cnt_inc = 3'b000;
        do_load(32'h2024_0131, 3'd4);
        cnt_inc = 3'b010; step();
        check("man_clamp_feb", Data, 32'h2024_0229);
        cnt_inc = 3'b000; step();
        cnt_inc = 3'b100; step();
        check("man_year_clamp", Data, 32'h2025_0228);
        check("man_wday_kept", {29'd0, wday}, 32'd4);
        cnt_inc = 3'b000; step();

        foreach (bad_loads[i]) begin
            do_load(bad_loads[i], 3'd1);
            check("bad_load_err", {31'd0, load_err}, 32'd1);
            check("bad_load_data", Data, 32'h2025_0228);
            step();
            check("bad_load_err_end", {31'd0, load_err}, 32'd0);
        end

        load_en = 1'b1; full_flag = 1'b1; load_data = 32'h2024_1231; load_wday = 3'd5;
        step();
        load_en = 1'b0; full_flag = 1'b0;
        check("load_beats_ff", Data, 32'h2024_1231);
        check("load_beats_ff_wday", {29'd0, wday}, 32'd5);

        cnt_inc = 3'b001; step();
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_data", Data, RST_DATE);
        check("async_rst_wday", {29'd0, wday}, 32'd6);
        model_reset();
        step(); step();
        Reset = 1'b0;
        repeat (5) step();
        check("held_after_rst", Data, RST_DATE);
        cnt_inc = 3'b000; step();
        cnt_inc = 3'b001; step();
        check("rearm_after_rst", Data, 32'h2025_0907);
        cnt_inc = 3'b000; step();

        for (int n = 0; n < 3000; n++) begin
            load_en = ($urandom_range(0, 99) < 6);
            if (load_en) begin
                if ($urandom_range(0, 1) == 1)
                    load_data = $urandom;
                else
                    load_data = i2b($urandom_range(1995, 2105), $urandom_range(0, 13), $urandom_range(0, 32));
                load_wday = 3'($urandom_range(0, 7));
            end
            full_flag = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) cnt_inc = 3'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                Reset = 1'b1;
                #1;
                check("rand_async_rst", Data, RST_DATE);
                model_reset();
                step();
                Reset = 1'b0;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
